// File: rtl/rx_signal_sequencer.sv
// 802.11a RX data-phase controller: checks the SIGNAL field and works out N_SYM.
// It paces decoding one OFDM symbol at a time and forwards only the PSDU bits, serially.
module rx_signal_sequencer #(
  parameter int SERVICE_BITS = 16,
  parameter int TAIL_BITS    = 6,
  parameter int CNT_W        = 16
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [23:0] iSig_Data,
  input  logic        iSig_Valid,
  input  logic        iAbort,
  input  logic        iBit,
  input  logic        iBit_Valid,
  output logic        oSym_Start,
  output logic        oData,
  output logic        oData_Valid,
  output logic [3:0]  oRate,
  output logic [11:0] oLength,
  output logic [1:0]  oMod,
  output logic [1:0]  oCode,
  output logic [10:0] oNum_Sym,
  output logic        oBusy,
  output logic        oSig_Err,
  output logic        oDone
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_CALC  = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  // Returns {valid, N_DBPS[7:0], mod[1:0], code[1:0]} for a {R1,R2,R3,R4} rate code.
  function automatic logic [12:0] f_rate_decode(input logic [3:0] i_code);
    logic [12:0] v_res;
    case (i_code)
      4'b1101: v_res = {1'b1, 8'd24,  2'd0, 2'd0};
      4'b1111: v_res = {1'b1, 8'd36,  2'd0, 2'd2};
      4'b0101: v_res = {1'b1, 8'd48,  2'd1, 2'd0};
      4'b0111: v_res = {1'b1, 8'd72,  2'd1, 2'd2};
      4'b1001: v_res = {1'b1, 8'd96,  2'd2, 2'd0};
      4'b1011: v_res = {1'b1, 8'd144, 2'd2, 2'd2};
      4'b0001: v_res = {1'b1, 8'd192, 2'd3, 2'd1};
      4'b0011: v_res = {1'b1, 8'd216, 2'd3, 2'd2};
      default: v_res = {1'b0, 8'd0,   2'd0, 2'd0};
    endcase
    return v_res;
  endfunction

  function automatic logic f_even_parity_ok(input logic [17:0] i_bits);
    return ~(^i_bits);
  endfunction

  state_t            r_state;
  state_t            w_state_next;
  logic [23:0]       r_sig;
  logic [7:0]        r_ndbps;
  logic [CNT_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_tot;
  logic [CNT_W-1:0]  r_psdu_end;
  logic [CNT_W-1:0]  r_bidx;
  logic [7:0]        r_bcnt;
  logic [10:0]       r_sym_cnt;
  logic [3:0]        r_rate;
  logic [11:0]       r_length;
  logic [1:0]        r_mod;
  logic [1:0]        r_code;
  logic [10:0]       r_num_sym;
  logic              r_sym_start;
  logic              r_data;
  logic              r_data_valid;
  logic              r_busy;
  logic              r_sig_err;
  logic              r_done;

  // RATE bits arrive R1 first, so iSig_Data[0] is the MSB of the {R1..R4} code.
  logic [3:0]        w_code;
  logic [12:0]       w_dec;
  logic [11:0]       w_len;
  logic              w_sig_ok;
  logic [CNT_W-1:0]  w_psdu_end;
  logic [CNT_W-1:0]  w_tot;
  logic [CNT_W-1:0]  w_acc_next;
  logic              w_calc_hit;
  logic              w_accept;
  logic              w_sym_end;
  logic              w_last_sym;
  logic              w_in_psdu;

  assign w_code     = {r_sig[0], r_sig[1], r_sig[2], r_sig[3]};
  assign w_dec      = f_rate_decode(w_code);
  assign w_len      = r_sig[16:5];
  assign w_sig_ok   = w_dec[12] & ~r_sig[4] & f_even_parity_ok(r_sig[17:0]) &
                      (r_sig[23:18] == 6'd0) & (w_len != 12'd0);
  assign w_psdu_end = CNT_W'(SERVICE_BITS) + CNT_W'({w_len, 3'b000});
  assign w_tot      = w_psdu_end + CNT_W'(TAIL_BITS);
  assign w_acc_next = r_acc + CNT_W'(r_ndbps);
  assign w_calc_hit = (w_acc_next >= r_tot);
  assign w_accept   = (r_state == ST_RUN) & iBit_Valid & ~iAbort;
  assign w_sym_end  = w_accept & ((r_bcnt + 8'd1) == r_ndbps);
  assign w_last_sym = ((r_sym_cnt + 11'd1) == r_num_sym);
  assign w_in_psdu  = (r_bidx >= CNT_W'(SERVICE_BITS)) & (r_bidx < r_psdu_end);

  // State register.
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; abort beats everything except a SIGNAL strobe in IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (iSig_Valid) w_state_next = ST_CHECK;
        else            w_state_next = ST_IDLE;
      end
      ST_CHECK: begin
        if (iAbort)        w_state_next = ST_IDLE;
        else if (w_sig_ok) w_state_next = ST_CALC;
        else               w_state_next = ST_IDLE;
      end
      ST_CALC: begin
        if (iAbort)          w_state_next = ST_IDLE;
        else if (w_calc_hit) w_state_next = ST_RUN;
        else                 w_state_next = ST_CALC;
      end
      ST_RUN: begin
        if (iAbort)                       w_state_next = ST_IDLE;
        else if (w_sym_end && w_last_sym) w_state_next = ST_IDLE;
        else                              w_state_next = ST_RUN;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Field latching, symbol-count division, bit counting and registered outputs.
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      r_sig        <= 24'd0;
      r_ndbps      <= 8'd0;
      r_acc        <= {CNT_W{1'b0}};
      r_tot        <= {CNT_W{1'b0}};
      r_psdu_end   <= {CNT_W{1'b0}};
      r_bidx       <= {CNT_W{1'b0}};
      r_bcnt       <= 8'd0;
      r_sym_cnt    <= 11'd0;
      r_rate       <= 4'd0;
      r_length     <= 12'd0;
      r_mod        <= 2'd0;
      r_code       <= 2'd0;
      r_num_sym    <= 11'd0;
      r_sym_start  <= 1'b0;
      r_data       <= 1'b0;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_sig_err    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_sym_start  <= 1'b0;
      r_data_valid <= 1'b0;
      r_sig_err    <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= (w_state_next != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (iSig_Valid) r_sig <= iSig_Data;
        end
        ST_CHECK: begin
          if (!iAbort && w_sig_ok) begin
            r_rate     <= w_code;
            r_length   <= w_len;
            r_mod      <= w_dec[3:2];
            r_code     <= w_dec[1:0];
            r_ndbps    <= w_dec[11:4];
            r_tot      <= w_tot;
            r_psdu_end <= w_psdu_end;
            r_acc      <= {CNT_W{1'b0}};
            r_num_sym  <= 11'd0;
          end else if (!iAbort) begin
            r_sig_err <= 1'b1;
          end
        end
        // Ceil division by repeated addition: one symbol per cycle.
        ST_CALC: begin
          if (!iAbort) begin
            r_acc     <= w_acc_next;
            r_num_sym <= r_num_sym + 11'd1;
            if (w_calc_hit) begin
              r_sym_start <= 1'b1;
              r_bidx      <= {CNT_W{1'b0}};
              r_bcnt      <= 8'd0;
              r_sym_cnt   <= 11'd0;
            end
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_bidx <= r_bidx + {{(CNT_W-1){1'b0}}, 1'b1};
            if (w_in_psdu) begin
              r_data       <= iBit;
              r_data_valid <= 1'b1;
            end
            if (w_sym_end) begin
              r_bcnt    <= 8'd0;
              r_sym_cnt <= r_sym_cnt + 11'd1;
              if (w_last_sym) r_done      <= 1'b1;
              else            r_sym_start <= 1'b1;
            end else begin
              r_bcnt <= r_bcnt + 8'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign oSym_Start  = r_sym_start;
  assign oData       = r_data;
  assign oData_Valid = r_data_valid;
  assign oRate       = r_rate;
  assign oLength     = r_length;
  assign oMod        = r_mod;
  assign oCode       = r_code;
  assign oNum_Sym    = r_num_sym;
  assign oBusy       = r_busy;
  assign oSig_Err    = r_sig_err;
  assign oDone       = r_done;

endmodule

// File: tb/tb_rx_signal_sequencer.sv
// Randomized bench for rx_signal_sequencer; a packet-level model predicts N_SYM,
// the PSDU bit stream and the pulse counts, and a negedge monitor compares every output bit.
module tb_rx_signal_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] sig_data;
  logic        sig_valid, abort_i, bit_i, bit_valid;
  logic        oSym_Start, oData, oData_Valid, oBusy, oSig_Err, oDone;
  logic [3:0]  oRate;
  logic [11:0] oLength;
  logic [1:0]  oMod, oCode;
  logic [10:0] oNum_Sym;

  rx_signal_sequencer dut (
    .iClk(clk), .iRst(rst_n), .iSig_Data(sig_data), .iSig_Valid(sig_valid),
    .iAbort(abort_i), .iBit(bit_i), .iBit_Valid(bit_valid),
    .oSym_Start(oSym_Start), .oData(oData), .oData_Valid(oData_Valid),
    .oRate(oRate), .oLength(oLength), .oMod(oMod), .oCode(oCode),
    .oNum_Sym(oNum_Sym), .oBusy(oBusy), .oSig_Err(oSig_Err), .oDone(oDone)
  );

  always #5 clk = ~clk;

  // Rate table keyed on {R1,R2,R3,R4}.
  localparam logic [3:0] RC   [8] = '{4'b1101, 4'b1111, 4'b0101, 4'b0111,
                                      4'b1001, 4'b1011, 4'b0001, 4'b0011};
  localparam int         NDB  [8] = '{24, 36, 48, 72, 96, 144, 192, 216};
  localparam int         MODT [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  localparam int         CRT  [8] = '{0, 2, 0, 2, 0, 2, 1, 2};

  int n_vec = 0;
  int n_err = 0;
  int cnt_sym = 0, cnt_done = 0, cnt_err = 0, cnt_dv = 0;
  bit exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rate_idx(input logic [3:0] c);
    for (int i = 0; i < 8; i++) if (RC[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [23:0] make_sig(input logic [3:0] code, input int len);
    logic [23:0] d;
    d = 24'd0;
    d[0] = code[3]; d[1] = code[2]; d[2] = code[1]; d[3] = code[0];
    d[16:5] = len[11:0];
    d[17] = ^d[16:0];
    return d;
  endfunction

  function automatic bit model_ok(input logic [23:0] d);
    logic [3:0] c;
    c = {d[0], d[1], d[2], d[3]};
    return (rate_idx(c) >= 0) && (d[4] == 1'b0) && ((^d[17:0]) == 1'b0) &&
           (d[23:18] == 6'd0) && (d[16:5] != 12'd0);
  endfunction

  function automatic int model_nsym(input int ndbps, input int len);
    return (16 + 8 * len + 6 + ndbps - 1) / ndbps;
  endfunction

  // Output monitor: pulse counters and the PSDU bit scoreboard.
  always @(negedge clk) begin
    if (oSym_Start) cnt_sym++;
    if (oDone)      cnt_done++;
    if (oSig_Err)   cnt_err++;
    if (oData_Valid) begin
      cnt_dv++;
      chk("data_queued", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("data", 32'(oData), 32'(exp_q.pop_front()));
      chk("done_vs_data", 32'(oDone), 32'd0);
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_pulse(input bit is_done, input int bound, input string name, output bit ok);
    int k;
    k = 0;
    while (!(is_done ? oDone : oSym_Start) && k < bound) begin
      @(negedge clk);
      k++;
    end
    ok = is_done ? oDone : oSym_Start;
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic recover();
    bit_valid = 1'b0; sig_valid = 1'b0; abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    @(negedge clk);
    exp_q.delete();
  endtask

  // mode 0: normal; 1: abort at (ev_sym, ev_bit); 2: one-cycle reset there.
  task automatic run_packet(input logic [3:0] code, input int len, input int mode,
                            input int ev_sym, input int ev_bit, input bit spur, input bit abort_with_sig);
    int idx, ndbps, nsym, b;
    bit ok;
    idx = rate_idx(code); ndbps = NDB[idx]; nsym = model_nsym(ndbps, len); b = 0;
    cnt_sym = 0; cnt_done = 0; cnt_err = 0; cnt_dv = 0;
    exp_q.delete();
    sig_data = make_sig(code, len); sig_valid = 1'b1; abort_i = abort_with_sig;
    @(negedge clk);
    sig_valid = 1'b0; abort_i = 1'b0;
    wait_pulse(1'b0, 3000, "first_sym_start", ok);
    if (!ok) begin recover(); return; end
    chk("num_sym", 32'(oNum_Sym), 32'(nsym));
    chk("rate", 32'(oRate), 32'(code));
    chk("length", 32'(oLength), 32'(len));
    chk("mod", 32'(oMod), 32'(MODT[idx]));
    chk("code", 32'(oCode), 32'(CRT[idx]));
    chk("busy_run", 32'(oBusy), 32'd1);
    for (int s = 0; s < nsym; s++) begin
      for (int j = 0; j < ndbps; j++) begin
        @(negedge clk);
        sig_valid = 1'b0;
        if (mode != 0 && s == ev_sym && j == ev_bit) begin
          bit_valid = 1'b0;
          if (mode == 1) abort_i = 1'b1; else rst_n = 1'b0;
          @(negedge clk);
          abort_i = 1'b0; rst_n = 1'b1;
          if (mode == 1) begin
            chk("abort_busy", 32'(oBusy), 32'd0);
            chk("abort_dv", 32'(oData_Valid), 32'd0);
          end else begin
            chk("rst_ctrl", 32'({oSym_Start, oData, oData_Valid, oBusy, oSig_Err, oDone,
                                 oMod, oCode, oRate}), 32'd0);
            chk("rst_fields", 32'({oLength, oNum_Sym}), 32'd0);
          end
          repeat (8) @(negedge clk);
          chk("ev_no_more_data", 32'(exp_q.size()), 32'd0);
          chk("ev_no_done", 32'(cnt_done), 32'd0);
          chk("ev_no_sig_err", 32'(cnt_err), 32'd0);
          if (mode == 1) chk("abort_hold_nsym", 32'(oNum_Sym), 32'(nsym));
          exp_q.delete();
          return;
        end
        while ($urandom_range(0, 3) == 0) begin
          bit_valid = 1'b0;
          @(negedge clk);
        end
        bit_i = 1'($urandom); bit_valid = 1'b1;
        if (spur && s == 0 && j == 2) begin
          sig_valid = 1'b1; sig_data = 24'($urandom);
        end
        if (b >= 16 && b < 16 + 8 * len) exp_q.push_back(bit_i);
        b++;
      end
      @(negedge clk);
      bit_valid = 1'b0; sig_valid = 1'b0;
      if (s < nsym - 1) wait_pulse(1'b0, 4, "sym_start", ok);
      else              wait_pulse(1'b1, 4, "done", ok);
      if (!ok) begin recover(); return; end
    end
    chk("busy_at_done", 32'(oBusy), 32'd0);
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("sym_start_count", 32'(cnt_sym), 32'(nsym));
    chk("done_count", 32'(cnt_done), 32'd1);
    chk("sig_err_count", 32'(cnt_err), 32'd0);
    chk("psdu_bits", 32'(cnt_dv), 32'(8 * len));
  endtask

  task automatic bad_sig(input logic [23:0] d, input string name);
    bit exp_err;
    exp_err = !model_ok(d);
    cnt_sym = 0; cnt_err = 0;
    sig_data = d; sig_valid = 1'b1;
    @(negedge clk);
    sig_valid = 1'b0;
    @(negedge clk);
    chk({name, "_err"}, 32'(oSig_Err), 32'(exp_err));
    chk({name, "_busy"}, 32'(oBusy), 32'(!exp_err));
    @(negedge clk);
    chk({name, "_pulse"}, 32'(cnt_err), 32'(exp_err));
    chk({name, "_no_sym"}, 32'(cnt_sym), 32'd0);
    if (!exp_err) recover();
  endtask

  initial begin
    logic [23:0] d;
    int kind;
    rst_n = 1'b0; sig_data = 24'd0; sig_valid = 1'b0; abort_i = 1'b0;
    bit_i = 1'b0; bit_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 32'({oSym_Start, oData, oData_Valid, oBusy, oSig_Err, oDone,
                           oMod, oCode, oRate}), 32'd0);
    chk("reset_fields", 32'({oLength, oNum_Sym}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Bits offered while idle must be ignored.
    cnt_dv = 0;
    for (int i = 0; i < 10; i++) begin
      bit_i = 1'($urandom); bit_valid = 1'b1;
      @(negedge clk);
    end
    bit_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_bits_ignored", 32'(cnt_dv), 32'd0);
    chk("idle_not_busy", 32'(oBusy), 32'd0);

    // 6 Mb/s, one octet.
    run_packet(4'b1101, 1, 0, 0, 0, 1'b0, 1'b0);
    chk("pin_6M_nsym", 32'(oNum_Sym), 32'd2);
    chk("pin_6M_bits", 32'(cnt_dv), 32'd8);
    chk("pin_6M_mod", 32'({oMod, oCode}), 32'd0);

    // 54 Mb/s, 100 octets.
    run_packet(4'b0011, 100, 0, 0, 0, 1'b0, 1'b0);
    chk("pin_54M_nsym", 32'(oNum_Sym), 32'd4);
    chk("pin_54M_mod", 32'(oMod), 32'd3);
    chk("pin_54M_code", 32'(oCode), 32'd2);
    chk("pin_54M_rate", 32'(oRate), 32'd3);
    chk("pin_54M_bits", 32'(cnt_dv), 32'd800);

    // Rejected SIGNAL fields.
    d = make_sig(4'b1101, 1); d[17] = ~d[17];
    bad_sig(d, "parity");
    bad_sig(make_sig(4'b0000, 5), "rate0");
    bad_sig(make_sig(4'b0101, 0), "len0");
    d = make_sig(4'b0101, 3); d[4] = 1'b1; d[17] = ~d[17];
    bad_sig(d, "reserved");
    d = make_sig(4'b1001, 9); d[20] = 1'b1;
    bad_sig(d, "tail");

    // Abort during symbol 2, then a fresh packet.
    run_packet(4'b0011, 100, 1, 1, 50, 1'b0, 1'b0);
    run_packet(4'b0101, 7, 0, 0, 0, 1'b0, 1'b0);

    // One-cycle reset mid-run, then a fresh packet.
    run_packet(4'b1001, 20, 2, 0, 30, 1'b0, 1'b0);
    run_packet(4'b1111, 3, 0, 0, 0, 1'b0, 1'b0);

    // Spurious SIGNAL strobe while running; abort coinciding with the SIGNAL strobe.
    run_packet(4'b0111, 12, 0, 0, 0, 1'b1, 1'b0);
    run_packet(4'b1011, 5, 0, 0, 0, 1'b0, 1'b1);

    // Randomized good packets.
    for (int p = 0; p < 8; p++) begin
      run_packet(RC[$urandom_range(0, 7)], int'($urandom_range(1, 150)), 0, 0, 0,
                 1'($urandom), 1'b0);
    end

    // Randomized single-field corruptions.
    for (int p = 0; p < 6; p++) begin
      d = make_sig(RC[$urandom_range(0, 7)], int'($urandom_range(1, 4095)));
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: d[17] = ~d[17];
        1: begin d[4] = 1'b1; d[17] = ~d[17]; end
        2: d[23:18] = 6'($urandom_range(1, 63));
        default: begin d[3:0] = 4'b0000; d[17] = ^d[16:0]; end
      endcase
      bad_sig(d, "rand_bad");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
